cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous active-high reset, in this port order:
- clock  in  1  rising-edge clock for all state
- reset  in  1  synchronous, active-high
- ula_in  in  16  arithmetic-ULA result word
- ula_ld_sd_in  in  16  address-ULA result word
- cdb  out  16  registered common-data-bus word; 16'hFFFF when idle
- cdb_valid  out  1  high for exactly one cycle per broadcast
- reg_we  out  3  one-hot register write enable; bit0 R0, bit1 R1, bit2 R2
- reg_wdata  out  16  broadcast data, zero-extended
- rs_release_alu  out  4  one-hot free of an arithmetic reservation-station slot
- rs_release_ldsd  out  4  one-hot free of a load/store reservation-station slot
- overflow  out  2  sticky drop flags; bit0 ula_in, bit1 ula_ld_sd_in
REQ-002 Input and cdb word format SHALL be: [15:13] one-hot destination (100 R0, 010 R1, 001 R2); [12:11] RS position; [10] unit tag (1 arithmetic, 0 load/store); [9:0] data.

Function
REQ-003 An input word SHALL be valid only if it is not 16'hFFFF and [15:13] is exactly one-hot; all other words SHALL be ignored.
REQ-004 Each source SHALL keep a last_seen register that loads the current input on every edge.
REQ-005 A source SHALL push its input into its FIFO on an edge where the input is valid and differs from last_seen, so a held word is captured once.
REQ-006 Two consecutive identical valid words with no intervening change SHALL be captured once; this is an accepted protocol limitation.
REQ-007 Each source SHALL have a private FIFO, depth 2, first-in first-out.
REQ-008 A push to a full FIFO SHALL be dropped and SHALL set that source's overflow bit, unless the same FIFO pops on that edge, in which case the push SHALL be accepted.
REQ-009 The block SHALL pop at most one word per edge across both FIFOs and load it into cdb.
REQ-010 Arbitration:
- only one FIFO non-empty: that FIFO is granted;
- both non-empty: a round-robin pointer decides;
- the pointer moves to the other source after every grant;
- the pointer resets to favour ula_in.
REQ-011 Latency SHALL be two edges: a word captured at edge N SHALL appear on cdb with cdb_valid=1 after edge N+1 at the earliest; there is no bypass path.
REQ-012 With no pop on an edge, the registered outputs SHALL load: cdb=16'hFFFF, cdb_valid=0, reg_we=0, reg_wdata=0, rs_release_alu=0, rs_release_ldsd=0.
REQ-013 On a broadcast, all outputs SHALL be registered together and decoded from the popped word:
- reg_we[0]=word[15], reg_we[1]=word[14], reg_we[2]=word[13];
- reg_wdata={6'b0, word[9:0]}.
REQ-014 rs_release routing:
- word[10]=1: rs_release_alu bit word[12:11] set, rs_release_ldsd=0;
- word[10]=0: the reverse.
REQ-015 Release routing SHALL follow word[10] and SHALL NOT depend on which port the word arrived on.
REQ-016 overflow bits SHALL stay set until reset.

Reset
REQ-017 While reset is high at an edge, the block SHALL load:
- cdb=16'hFFFF, cdb_valid=0, reg_we=0, reg_wdata=0;
- rs_release_alu=0, rs_release_ldsd=0, overflow=0;
- both FIFOs empty, both last_seen=16'hFFFF, pointer favouring ula_in.
REQ-018 Reset asserted mid-operation SHALL discard all queued words with no broadcast.
REQ-019 A valid input held across reset release SHALL be captured on the first edge after release.

Verification
REQ-020 A bench SHALL cover these scenarios:
- Single word: reset, then ula_ld_sd_in=16'h2005 held -> one broadcast two edges later: cdb=16'h2005, reg_we=3'b100, reg_wdata=16'h0005, rs_release_ldsd=4'b0001; then idle values every cycle.
- Simultaneous: ula_in=16'h4C12 and ula_ld_sd_in=16'h2803 change on the same edge -> 16'h4C12 broadcast first, 16'h2803 on the next cycle; rs_release_alu=4'b0010, then rs_release_ldsd=4'b0010.
- Overflow: three different ula_in words pushed while ula_ld_sd_in supplies a new word every cycle -> overflow stays 2'b00 (round-robin pops in time); after forced saturation (both inputs change every cycle for 6 cycles), overflow sets and holds until reset.
- Invalid words: ula_in=16'hFFFF, then 16'hE001 (not one-hot) -> no broadcast; cdb stays 16'hFFFF.
- Reset mid-queue: two words queued, reset pulsed for one cycle -> no broadcast; a held valid input is re-captured and broadcast two edges after release.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: captures new valid words from two result sources into
// private 2-deep FIFOs and broadcasts at most one word per cycle, round-robin.
module cdb_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] ula_in,
  input  logic [15:0] ula_ld_sd_in,
  output logic [15:0] cdb,
  output logic        cdb_valid,
  output logic [2:0]  reg_we,
  output logic [15:0] reg_wdata,
  output logic [3:0]  rs_release_alu,
  output logic [3:0]  rs_release_ldsd,
  output logic [1:0]  overflow
);

  localparam logic [15:0] IdleWord = 16'hFFFF;

  // A word is meaningful only with an exactly one-hot destination field.
  function automatic logic word_valid(input logic [15:0] w);
    return (w != IdleWord) &&
           ((w[15:13] == 3'b100) || (w[15:13] == 3'b010) || (w[15:13] == 3'b001));
  endfunction

  // Source 0 is ula_in, source 1 is ula_ld_sd_in.
  logic [1:0][15:0] in_w;
  assign in_w = {ula_ld_sd_in, ula_in};

  logic [1:0][15:0]       last_q, last_d;
  logic [1:0][1:0][15:0]  mem_q, mem_d;
  logic [1:0]             rd_q, rd_d;
  logic [1:0][1:0]        cnt_q, cnt_d;
  logic                   ptr_q, ptr_d;     // 0 favours ula_in
  logic [1:0]             ovf_q, ovf_d;
  logic [15:0]            cdb_q, cdb_d;
  logic                   valid_q, valid_d;
  logic [2:0]             we_q, we_d;
  logic [15:0]            wdata_q, wdata_d;
  logic [3:0]             alu_q, alu_d;
  logic [3:0]             ldsd_q, ldsd_d;

  logic [1:0]  ne, gnt, push, acc;
  logic [1:0]  wr_idx;
  logic [15:0] pop_word;

  // Next-state: capture, FIFO update, arbitration and output decode.
  always_comb begin
    last_d   = last_q;
    mem_d    = mem_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    ovf_d    = ovf_q;
    push     = '0;
    acc      = '0;
    wr_idx   = '0;
    cdb_d    = IdleWord;
    valid_d  = 1'b0;
    we_d     = '0;
    wdata_d  = '0;
    alu_d    = '0;
    ldsd_d   = '0;

    ne[0]  = (cnt_q[0] != 2'd0);
    ne[1]  = (cnt_q[1] != 2'd0);
    gnt[0] = ne[0] && (!ne[1] || !ptr_q);
    gnt[1] = ne[1] && (!ne[0] || ptr_q);

    for (int i = 0; i < 2; i++) begin
      last_d[i] = in_w[i];
      push[i]   = word_valid(in_w[i]) && (in_w[i] != last_q[i]);
      if (gnt[i]) rd_d[i] = ~rd_q[i];
      // A full FIFO that pops this cycle frees the slot at rd_q for the new word.
      if (push[i]) begin
        if ((cnt_q[i] != 2'd2) || gnt[i]) begin
          acc[i]              = 1'b1;
          wr_idx[i]           = rd_q[i] ^ cnt_q[i][0];
          mem_d[i][wr_idx[i]] = in_w[i];
        end else begin
          ovf_d[i] = 1'b1;
        end
      end
      cnt_d[i] = cnt_q[i] + {1'b0, acc[i]} - {1'b0, gnt[i]};
    end

    pop_word = gnt[0] ? mem_q[0][rd_q[0]] : mem_q[1][rd_q[1]];

    if (gnt != 2'b00) begin
      ptr_d   = gnt[0];
      cdb_d   = pop_word;
      valid_d = 1'b1;
      we_d    = {pop_word[13], pop_word[14], pop_word[15]};
      wdata_d = {6'b0, pop_word[9:0]};
      if (pop_word[10]) alu_d  = 4'b0001 << pop_word[12:11];
      else              ldsd_d = 4'b0001 << pop_word[12:11];
    end
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_q  <= {IdleWord, IdleWord};
      mem_q   <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      ovf_q   <= '0;
      cdb_q   <= IdleWord;
      valid_q <= 1'b0;
      we_q    <= '0;
      wdata_q <= '0;
      alu_q   <= '0;
      ldsd_q  <= '0;
    end else begin
      last_q  <= last_d;
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      cdb_q   <= cdb_d;
      valid_q <= valid_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      alu_q   <= alu_d;
      ldsd_q  <= ldsd_d;
    end
  end

  assign cdb             = cdb_q;
  assign cdb_valid       = valid_q;
  assign reg_we          = we_q;
  assign reg_wdata       = wdata_q;
  assign rs_release_alu  = alu_q;
  assign rs_release_ldsd = ldsd_q;
  assign overflow        = ovf_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with hand-computed expectations.
module tb_cdb_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] ula_in, ula_ld_sd_in;
  logic [15:0] cdb;
  logic        cdb_valid;
  logic [2:0]  reg_we;
  logic [15:0] reg_wdata;
  logic [3:0]  rs_release_alu, rs_release_ldsd;
  logic [1:0]  overflow;

  int tests = 0;
  int fails = 0;

  cdb_arbiter dut (
    .clock           (clock),
    .reset           (reset),
    .ula_in          (ula_in),
    .ula_ld_sd_in    (ula_ld_sd_in),
    .cdb             (cdb),
    .cdb_valid       (cdb_valid),
    .reg_we          (reg_we),
    .reg_wdata       (reg_wdata),
    .rs_release_alu  (rs_release_alu),
    .rs_release_ldsd (rs_release_ldsd),
    .overflow        (overflow)
  );

  always #5 clock = ~clock;

  // One edge, then settle so inputs/outputs are handled away from the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " cdb"}, cdb, 16'hFFFF);
    check({tag, " valid"}, {15'd0, cdb_valid}, 16'd0);
    check({tag, " we"}, {13'd0, reg_we}, 16'd0);
    check({tag, " wdata"}, reg_wdata, 16'd0);
    check({tag, " rel"}, {8'd0, rs_release_alu, rs_release_ldsd}, 16'd0);
  endtask

  task automatic check_bc(input string tag, input logic [15:0] w, input logic [2:0] we,
                          input logic [3:0] alu, input logic [3:0] ldsd);
    check({tag, " cdb"}, cdb, w);
    check({tag, " valid"}, {15'd0, cdb_valid}, 16'd1);
    check({tag, " we"}, {13'd0, reg_we}, {13'd0, we});
    check({tag, " wdata"}, reg_wdata, {6'd0, w[9:0]});
    check({tag, " rel"}, {8'd0, rs_release_alu, rs_release_ldsd}, {8'd0, alu, ldsd});
  endtask

  task automatic do_reset();
    ula_in       = 16'hFFFF;
    ula_ld_sd_in = 16'hFFFF;
    reset        = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [15:0] uw [3];
  logic [15:0] lw [3];
  logic [15:0] exp_seq [6];

  initial begin
    uw = '{16'h8401, 16'h8402, 16'h8403};
    lw = '{16'h4001, 16'h4002, 16'h4003};
    exp_seq = '{16'h8401, 16'h4001, 16'h8402, 16'h4002, 16'h8403, 16'h4003};

    // Reset state
    do_reset();
    check_idle("reset");
    check("reset ovf", {14'd0, overflow}, 16'd0);

    // Single word, held input captured once
    ula_ld_sd_in = 16'h2005;
    tick();
    check_idle("single lat1");
    tick();
    check_bc("single", 16'h2005, 3'b100, 4'b0000, 4'b0001);
    tick();
    check_idle("single idle1");
    tick();
    check_idle("single idle2");

    // Simultaneous arrival: ula_in wins first
    do_reset();
    ula_in       = 16'h4C12;
    ula_ld_sd_in = 16'h2803;
    tick();
    check_idle("simul lat1");
    tick();
    check_bc("simul first", 16'h4C12, 3'b010, 4'b0010, 4'b0000);
    tick();
    check_bc("simul second", 16'h2803, 3'b100, 4'b0000, 4'b0010);
    tick();
    check_idle("simul idle");

    // Three words per source without overflow; round-robin order on the bus
    do_reset();
    for (int k = 0; k < 3; k++) begin
      ula_in       = uw[k];
      ula_ld_sd_in = lw[k];
      tick();
      if (k >= 1) check($sformatf("rr pop%0d", k - 1), cdb, exp_seq[k - 1]);
    end
    for (int k = 2; k < 6; k++) begin
      tick();
      check($sformatf("rr pop%0d", k), cdb, exp_seq[k]);
    end
    check("rr ovf", {14'd0, overflow}, 16'd0);
    tick();
    check_idle("rr drained");

    // Forced saturation: both sources change every cycle
    for (int k = 0; k < 6; k++) begin
      ula_in       = (k % 2 == 0) ? 16'h8411 : 16'h8412;
      ula_ld_sd_in = (k % 2 == 0) ? 16'h2011 : 16'h2012;
      tick();
    end
    check("sat ovf", {14'd0, overflow}, 16'h0003);
    for (int k = 0; k < 6; k++) tick();
    check("sat ovf sticky", {14'd0, overflow}, 16'h0003);
    do_reset();
    check("sat ovf cleared", {14'd0, overflow}, 16'd0);

    // Invalid words are ignored
    ula_in = 16'hFFFF;
    tick();
    ula_in = 16'hE001;
    tick();
    check_idle("invalid 1");
    tick();
    check_idle("invalid 2");
    tick();
    check_idle("invalid 3");

    // Reset mid-queue discards words; held inputs re-captured after release
    do_reset();
    ula_in       = 16'h8401;
    ula_ld_sd_in = 16'h4001;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("midrst during");
    tick();
    check_idle("midrst recapture");
    tick();
    check_bc("midrst first", 16'h8401, 3'b001, 4'b0001, 4'b0000);
    tick();
    check_bc("midrst second", 16'h4001, 3'b010, 4'b0000, 4'b0001);
    tick();
    check_idle("midrst idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
